tile_collector: RTL and testbench
=================================

# tile_collector

Consumes the per-cycle `metric_o`/`msg_o` result stream of one hashing tile. Keeps the best candidate seen since the last clear, where a lower metric is better and 0 is an exact digest match. When that best candidate meets a programmable threshold, it freezes the result and serialises it to the host over a 32-bit valid/ready stream. It sits between a tile and the host readout path, one instance per tile.

## Interface
- `MSG_W`, default 512: message width in bits; must be a multiple of 32.
- `METRIC_W`, default 9: metric width, matching the tile metric output of `$clog2(161)+1` bits.
- `clk_i`  in  1  clock; single clock domain.
- `reset_i`  in  1  reset, synchronous, active-high.
- `in_val_i`  in  1  tile result valid. Low during pipeline warm-up.
- `metric_i`  in  METRIC_W  candidate metric. Lower is better.
- `msg_i`  in  MSG_W  candidate message aligned with `metric_i`.
- `thresh_i`  in  METRIC_W  report threshold. Sampled continuously.
- `clear_i`  in  1  restart search; single-cycle pulse.
- `best_metric_o`  out  METRIC_W  current best metric.
- `found_o`  out  1  high from entry to SEND until clear or reset.
- `out_val_o`  out  1  stream word valid.
- `out_rdy_i`  in  1  stream word ready.
- `out_data_o`  out  32  stream word.
- `out_last_o`  out  1  marks the final word of the stream.

## Operation
- States: TRACK, SEND, DONE. Reset state is TRACK.
- Reset values:
  - `best_metric_o` = all ones; best message register = 0.
  - `found_o`, `out_val_o`, `out_last_o` = 0; `out_data_o` = 0.
  - Word index = 0.
- TRACK, update rule:
  - If `in_val_i` and `metric_i` < best (unsigned, strict), load `metric_i`/`msg_i` into the best registers.
  - On a tie, the older candidate is kept.
- TRACK, exit to SEND: go to SEND on the next cycle if either condition holds:
  - (update taken and `metric_i` <= `thresh_i`); or
  - (registered best <= `thresh_i`). This catches a threshold raised later.
- SEND, frozen snapshot: inputs are ignored and the best registers are frozen.
- SEND, words emitted in order:
  - Word 0: `{zero-extended best metric}`.
  - Then MSG_W/32 message words, most-significant first (`msg[MSG_W-1 -: 32]` first).
  - `out_last_o` is high on the final word only.
- SEND, handshake: a word transfers when `out_val_o && out_rdy_i`. After the last transfer the FSM goes to DONE.
- DONE: `out_val_o` = 0; `found_o` is held; results are ignored.
- `clear_i` in any state:
  - Next cycle: state = TRACK; best = all ones; word index = 0; `found_o` = 0; `out_val_o` = 0.
  - Aborts any SEND in progress. A partial stream is legal and has no `out_last_o`.
- `clear_i` and `in_val_i` in the same cycle: the clear wins and the candidate is discarded.
- `reset_i` mid-stream: same effect as clear, and all outputs return to reset values.

## Timing
- Best-update latency: result at cycle t → `best_metric_o` updated at t+1.
- Threshold hit at cycle t → at t+1: SEND, `found_o` = 1, `out_val_o` = 1, word 0 on `out_data_o`.
- `out_data_o`/`out_val_o`/`out_last_o` are registered. They are held stable while `out_val_o && !out_rdy_i`.
- One word per cycle when `out_rdy_i` is held high: stream length L → DONE at t+1+L.
- Throughput in TRACK: one candidate per cycle, no back-pressure to the tile.

## Configuration
- Macro: `TILE_COLLECTOR_COUNT_EN`.
- Defined:
  - A 32-bit saturating counter counts `in_val_i` beats since the last clear/reset.
  - The counter is frozen on entry to SEND.
  - It is sent as word 1, between the metric word and the message.
  - Stream length is MSG_W/32+2.
- Undefined: no counter; stream length is MSG_W/32+1.

## Structure
- Package `collector_pkg` holds:
  - The state enum (TRACK, SEND, DONE).
  - `WORD_W = 32`.
  - A function returning the stream length for a given MSG_W.
- One sub-module: `word_serializer`.
  - Takes the frozen snapshot as a flat vector plus a start pulse.
  - Drives `out_val_o`/`out_data_o`/`out_last_o` with an internal word index.
  - Has its own abort input, driven by clear.
- Compare/track logic and the FSM stay in `tile_collector`.

## Test plan
All scenarios use MSG_W=512 and the counter disabled unless stated.
- Reset, then no input → `best_metric_o` = 9'h1FF; `found_o` = 0; `out_val_o` = 0.
- Metrics 80, 75, 75, 90 with `thresh_i` = 0 → best = 75, and best message = the first 75 candidate (tie keeps older); still TRACK.
- Metric 3 with `thresh_i` = 5 → next cycle `found_o` = 1 and word 0 = 32'd3. Then 16 message words, MSB word first; `out_last_o` only on word 16; then DONE.
- `out_rdy_i` toggling 1,0,0,1 during SEND → each word held stable until accepted; no word lost or duplicated.
- `clear_i` after 5 of 17 words → `out_val_o` = 0 next cycle and best = 9'h1FF. A new hit restarts the stream at word 0.
- `TILE_COLLECTOR_COUNT_EN` defined, 1000 valid beats then a hit → word 1 = 32'd1000 and stream length 18.

Source files
------------

// File: rtl/collector_pkg.sv
// rtl/collector_pkg.sv - shared types and helpers for tile_collector
// Purpose: FSM state enum, stream word width and stream length helper.
// Config macro: TILE_COLLECTOR_COUNT_EN adds the beat-counter word to the stream.
package collector_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    TRACK = 2'd0,
    SEND  = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Number of 32-bit words in one result stream: metric word, optional
  // beat-count word, then the message words.
  function automatic int stream_len(input int msg_w);
`ifdef TILE_COLLECTOR_COUNT_EN
    return msg_w / WORD_W + 2;
`else
    return msg_w / WORD_W + 1;
`endif
  endfunction

endpackage

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - emits a snapshot vector as a stream of 32-bit words
// Purpose: on start_i, walks snap_i from its most-significant word down,
//          one word per accepted handshake.
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   start_i               begin a new stream (snap_i must be valid this cycle)
//   abort_i               drop the stream in progress, no last marker
//   snap_i                N_WORDS*32 flat snapshot, word 0 in the top bits
//   out_rdy_i             sink ready
//   out_val_o/out_data_o  registered stream word and its valid
//   out_last_o            registered, high on the final word only
//   done_o                combinational pulse: final word transfers this cycle
module word_serializer
  import collector_pkg::*;
#(
  parameter int N_WORDS = 17
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [N_WORDS*WORD_W-1:0] snap_i,
  input  logic                      out_rdy_i,
  output logic                      out_val_o,
  output logic [WORD_W-1:0]         out_data_o,
  output logic                      out_last_o,
  output logic                      done_o
);

  localparam int IDX_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int SNAP_W = N_WORDS * WORD_W;

  logic [WORD_W-1:0] words [N_WORDS];
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_nxt;
  logic              xfer;

  for (genvar k = 0; k < N_WORDS; k++) begin : g_words
    assign words[k] = snap_i[SNAP_W-1-k*WORD_W -: WORD_W];
  end

  assign xfer    = out_val_o && out_rdy_i;
  assign done_o  = xfer && out_last_o;
  assign idx_nxt = idx_q + 1'b1;

  // The next word is preloaded on each transfer so the outputs stay purely
  // registered and hold still while the sink stalls.
  always_ff @(posedge clk_i) begin
    if (reset_i || abort_i) begin
      idx_q      <= '0;
      out_val_o  <= 1'b0;
      out_data_o <= '0;
      out_last_o <= 1'b0;
    end else if (start_i) begin
      idx_q      <= '0;
      out_val_o  <= 1'b1;
      out_data_o <= words[0];
      out_last_o <= (N_WORDS == 1);
    end else if (xfer) begin
      if (out_last_o) begin
        idx_q      <= '0;
        out_val_o  <= 1'b0;
        out_last_o <= 1'b0;
      end else begin
        idx_q      <= idx_nxt;
        out_data_o <= words[idx_nxt];
        out_last_o <= (idx_nxt == IDX_W'(N_WORDS - 1));
      end
    end
  end

endmodule

// File: rtl/tile_collector.sv
// rtl/tile_collector.sv - best-candidate tracker and result streamer for one tile
// Purpose: keeps the lowest metric (and its message) seen since the last clear;
//          once it meets thresh_i the result is frozen and streamed out.
// Config macro: TILE_COLLECTOR_COUNT_EN adds a saturating in_val_i beat counter,
//          sent as word 1 between the metric word and the message.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   in_val_i            tile result valid
//   metric_i, msg_i     candidate metric (lower is better) and its message
//   thresh_i            report threshold, sampled every cycle
//   clear_i             restart the search, aborts any stream in progress
//   best_metric_o       current best metric
//   found_o             high from entry to SEND until clear/reset
//   out_val_o, out_rdy_i, out_data_o, out_last_o   32-bit result stream
module tile_collector
  import collector_pkg::*;
#(
  parameter int MSG_W    = 512,
  parameter int METRIC_W = 9
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                in_val_i,
  input  logic [METRIC_W-1:0] metric_i,
  input  logic [MSG_W-1:0]    msg_i,
  input  logic [METRIC_W-1:0] thresh_i,
  input  logic                clear_i,
  output logic [METRIC_W-1:0] best_metric_o,
  output logic                found_o,
  output logic                out_val_o,
  input  logic                out_rdy_i,
  output logic [WORD_W-1:0]   out_data_o,
  output logic                out_last_o
);

  localparam int N_WORDS = stream_len(MSG_W);
  localparam int SNAP_W  = N_WORDS * WORD_W;

  state_e              state_q;
  logic [METRIC_W-1:0] best_metric_q;
  logic [METRIC_W-1:0] best_metric_d;
  logic [MSG_W-1:0]    best_msg_q;
  logic [MSG_W-1:0]    best_msg_d;
  logic                found_q;
  logic                in_track;
  logic                update;
  logic                hit;
  logic                ser_start;
  logic                ser_done;
  logic [SNAP_W-1:0]   snap;

  assign in_track = (state_q == TRACK);

  // Strict compare: on a tie the older candidate stays.
  assign update = in_track && in_val_i && (metric_i < best_metric_q);

  // Second term fires when the threshold is raised above an already-held best.
  assign hit = in_track &&
               ((update && (metric_i <= thresh_i)) || (best_metric_q <= thresh_i));

  // Snapshot is taken from the next-state best values so word 0 is on the
  // stream in the very cycle after the hit. Outside TRACK these equal the
  // frozen registers, which keeps the serializer input stable during SEND.
  assign best_metric_d = update ? metric_i : best_metric_q;
  assign best_msg_d    = update ? msg_i    : best_msg_q;
  assign ser_start     = hit && !clear_i;

`ifdef TILE_COLLECTOR_COUNT_EN
  logic [WORD_W-1:0] count_q;
  logic [WORD_W-1:0] count_d;

  // Counts only while tracking, so it freezes on entry to SEND.
  assign count_d = (in_track && in_val_i && (count_q != '1)) ? count_q + 1'b1 : count_q;
  assign snap    = {{(WORD_W-METRIC_W){1'b0}}, best_metric_d, count_d, best_msg_d};

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  assign snap = {{(WORD_W-METRIC_W){1'b0}}, best_metric_d, best_msg_d};
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      state_q       <= TRACK;
      best_metric_q <= '1;
      best_msg_q    <= '0;
      found_q       <= 1'b0;
    end else begin
      case (state_q)
        TRACK: begin
          best_metric_q <= best_metric_d;
          best_msg_q    <= best_msg_d;
          if (hit) begin
            state_q <= SEND;
            found_q <= 1'b1;
          end
        end
        SEND: begin
          if (ser_done) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= TRACK;
        end
      endcase
    end
  end

  word_serializer #(
    .N_WORDS(N_WORDS)
  ) u_ser (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (ser_start),
    .abort_i   (clear_i),
    .snap_i    (snap),
    .out_rdy_i (out_rdy_i),
    .out_val_o (out_val_o),
    .out_data_o(out_data_o),
    .out_last_o(out_last_o),
    .done_o    (ser_done)
  );

  assign best_metric_o = best_metric_q;
  assign found_o       = found_q;

endmodule

// File: tb/tb_tile_collector.sv
// tb/tb_tile_collector.sv - self-checking bench for tile_collector
module tb_tile_collector;

  localparam int MSG_W    = 512;
  localparam int METRIC_W = 9;
  localparam int NW       = MSG_W / 32;
`ifdef TILE_COLLECTOR_COUNT_EN
  localparam int LEN = NW + 2;
`else
  localparam int LEN = NW + 1;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                in_val;
  logic [METRIC_W-1:0] metric;
  logic [MSG_W-1:0]    msg;
  logic [METRIC_W-1:0] thresh;
  logic                clear;
  logic                rdy;
  logic [METRIC_W-1:0] best_metric;
  logic                found;
  logic                out_val;
  logic [31:0]         out_data;
  logic                out_last;

  tile_collector #(.MSG_W(MSG_W), .METRIC_W(METRIC_W)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .in_val_i     (in_val),
    .metric_i     (metric),
    .msg_i        (msg),
    .thresh_i     (thresh),
    .clear_i      (clear),
    .best_metric_o(best_metric),
    .found_o      (found),
    .out_val_o    (out_val),
    .out_rdy_i    (rdy),
    .out_data_o   (out_data),
    .out_last_o   (out_last)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: the search is "earliest minimum over all candidates
  // accepted since the last clear"; the stream is an explicit word list.
  typedef struct {
    logic [METRIC_W-1:0] metric;
    logic [MSG_W-1:0]    msg;
  } cand_t;

  cand_t               cands[$];
  int                  m_phase;   // 0 tracking, 1 streaming, 2 finished
  logic [METRIC_W-1:0] m_best;
  logic [MSG_W-1:0]    m_msg;
  bit                  m_found;
  logic [31:0]         m_words[$];
  int                  m_pos;
  logic [31:0]         m_count;
  logic [31:0]         rx[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [MSG_W-1:0] mk_msg(input int seed);
    logic [MSG_W-1:0] r;
    for (int k = 0; k < NW; k++) r[32*k +: 32] = 32'(seed) * 32'h100 + 32'(k);
    return r;
  endfunction

  task automatic model_reset();
    cands.delete();
    m_words.delete();
    m_phase = 0;
    m_best  = '1;
    m_msg   = '0;
    m_found = 1'b0;
    m_pos   = 0;
    m_count = 0;
  endtask

  task automatic model_step();
    if (reset || clear) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (in_val) begin
        cands.push_back('{metric, msg});
        if (m_count != 32'hFFFF_FFFF) m_count++;
      end
      m_best = '1;
      m_msg  = '0;
      foreach (cands[i]) begin
        if (cands[i].metric < m_best) begin
          m_best = cands[i].metric;
          m_msg  = cands[i].msg;
        end
      end
      if (m_best <= thresh) begin
        m_phase = 1;
        m_found = 1'b1;
        m_pos   = 0;
        m_words.delete();
        m_words.push_back(32'(m_best));
`ifdef TILE_COLLECTOR_COUNT_EN
        m_words.push_back(m_count);
`endif
        for (int k = 0; k < NW; k++) m_words.push_back(m_msg[MSG_W-1-32*k -: 32]);
      end
    end else if (m_phase == 1) begin
      if (rdy) begin
        m_pos++;
        if (m_pos == LEN) m_phase = 2;
      end
    end
  endtask

  task automatic check_model();
    chk("best", 32'(best_metric), 32'(m_best));
    chk("found", 32'(found), 32'(m_found));
    chk("val", 32'(out_val), 32'(m_phase == 1));
    chk("last", 32'(out_last), 32'(m_phase == 1 && m_pos == LEN - 1));
    if (m_phase == 1) chk("data", out_data, m_words[m_pos]);
  endtask

  task automatic tick();
    if (out_val && rdy && !reset && !clear) rx.push_back(out_data);
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    bit                  v;
    logic [METRIC_W-1:0] m;
    logic [METRIC_W-1:0] th;
    logic [METRIC_W-1:0] e_best;
    bit                  e_found;
    bit                  e_val;
  } vec_t;

  vec_t        tbl[6];
  logic [31:0] exp_q[$];
  logic [MSG_W-1:0] tmp_msg;
  int          nxfer;

  initial begin
    tbl[0] = '{1'b1, 9'd80, 9'd0,  9'd80, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 9'd75, 9'd0,  9'd75, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 9'd75, 9'd0,  9'd75, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 9'd90, 9'd0,  9'd75, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 9'd0,  9'd0,  9'd75, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 9'd0,  9'd75, 9'd75, 1'b1, 1'b1};

    reset = 1'b1; in_val = 1'b0; metric = '0; msg = '0; thresh = '0; clear = 1'b0; rdy = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_best", 32'(best_metric), 32'h1FF);
    chk("rst_data", out_data, 32'h0);

    // Tie keeps the older candidate; a later threshold raise triggers SEND.
    for (int i = 0; i < 6; i++) begin
      in_val = tbl[i].v; metric = tbl[i].m; msg = mk_msg(i + 1); thresh = tbl[i].th;
      tick();
      chk("tbl_best", 32'(best_metric), 32'(tbl[i].e_best));
      chk("tbl_found", 32'(found), 32'(tbl[i].e_found));
      chk("tbl_val", 32'(out_val), 32'(tbl[i].e_val));
    end
    in_val = 1'b0;
    chk("tbl_word0", out_data, 32'd75);

    // Back-pressure 1,0,0,1: collected words must be exactly the stream.
    rx.delete();
    for (int c = 0; c < 200 && out_val; c++) begin
      rdy = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    rdy = 1'b1;
    exp_q.delete();
    tmp_msg = mk_msg(2);
    exp_q.push_back(32'd75);
`ifdef TILE_COLLECTOR_COUNT_EN
    exp_q.push_back(32'd4);
`endif
    for (int k = 0; k < NW; k++) exp_q.push_back(tmp_msg[MSG_W-1-32*k -: 32]);
    chk("stall_len", 32'(rx.size()), 32'(LEN));
    for (int k = 0; k < LEN && k < rx.size(); k++) chk("stall_word", rx[k], exp_q[k]);
    chk("done_val", 32'(out_val), 32'd0);
    chk("done_found", 32'(found), 32'd1);
    in_val = 1'b1; metric = 9'd0; thresh = 9'd5;
    tick();
    in_val = 1'b0;
    chk("done_ignore", 32'(best_metric), 32'd75);

    // Hit on metric 3: word 0 next cycle, last only on the final word.
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_best", 32'(best_metric), 32'h1FF);
    in_val = 1'b1; metric = 9'd3; thresh = 9'd5; msg = mk_msg(50);
    tick();
    in_val = 1'b0;
    chk("hit_found", 32'(found), 32'd1);
    chk("hit_val", 32'(out_val), 32'd1);
    chk("hit_word0", out_data, 32'd3);
    for (int j = 0; j < LEN; j++) begin
      chk("hit_last", 32'(out_last), 32'(j == LEN - 1));
      tick();
    end
    chk("hit_done", 32'(out_val), 32'd0);

    // Abort after 5 words, then restart with a new hit.
    clear = 1'b1; tick(); clear = 1'b0;
    in_val = 1'b1; metric = 9'd2; thresh = 9'd5; msg = mk_msg(60);
    tick();
    in_val = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("abort_val", 32'(out_val), 32'd0);
    chk("abort_best", 32'(best_metric), 32'h1FF);
    chk("abort_found", 32'(found), 32'd0);
    in_val = 1'b1; metric = 9'd4; msg = mk_msg(70);
    tick();
    in_val = 1'b0;
    chk("restart_word0", out_data, 32'd4);
    for (int c = 0; c < 100 && out_val; c++) tick();
    chk("restart_done", 32'(out_val), 32'd0);

`ifdef TILE_COLLECTOR_COUNT_EN
    // 1000 beats, then a hit via threshold raise with no extra beat.
    clear = 1'b1; tick(); clear = 1'b0;
    in_val = 1'b1; metric = 9'd3; thresh = 9'd0; msg = mk_msg(80);
    for (int j = 0; j < 1000; j++) tick();
    in_val = 1'b0; thresh = 9'd5;
    tick();
    chk("cnt_word0", out_data, 32'd3);
    nxfer = 1;
    tick();
    chk("cnt_word1", out_data, 32'd1000);
    for (int c = 0; c < 100 && out_val; c++) begin
      nxfer++;
      tick();
    end
    chk("cnt_len", 32'(nxfer), 32'd18);
`endif

    // Random traffic against the model.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(0, 999) == 0);
      clear  = ($urandom_range(0, 39) == 0);
      in_val = ($urandom_range(0, 3) != 0);
      metric = METRIC_W'($urandom_range(0, 160));
      thresh = ($urandom_range(0, 3) != 0) ? '0 : METRIC_W'($urandom_range(0, 12));
      for (int k = 0; k < NW; k++) msg[32*k +: 32] = $urandom;
      rdy    = ($urandom_range(0, 9) < 7);
      tick();
    end
    reset = 1'b0; clear = 1'b0; in_val = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
